fanout_fork_ctrl: RTL and testbench
===================================

// Module: fanout_fork_ctrl
// PURPOSE
//   Eager-fork controller for one ready/valid producer driving up to NUM_OUT consumers in the CGRA
//   interconnect. It tracks which selected consumers have already taken the current token, so a slow
//   consumer does not block fast ones from accepting it.
//   Replaces the purely combinational all-ready fanout AND with a registered per-consumer done mask.
//   Adds deferred config load, a stall watchdog and a token counter.
// PARAMETERS
//   NUM_OUT      9      number of downstream consumers (1..32)
//   STALL_LIMIT  1024   cycles a token may stay outstanding before stall_flag asserts (>=1)
//   CNT_W        16     width of token counter
// PORTS
//   clk           in   1          clock
//   rst_n         in   1          async active-low reset
//   cfg_we        in   1          load cfg_sel_in as new consumer select mask
//   cfg_sel_in    in   NUM_OUT    consumer select mask (1 = consumer participates)
//   cfg_sel       out  NUM_OUT    active select mask
//   valid_in      in   1          producer valid
//   ready_out     out  1          producer ready (token retired this cycle)
//   valid_o       out  NUM_OUT    per-consumer valid
//   ready_i       in   NUM_OUT    per-consumer ready
//   stall_flag    out  1          sticky: outstanding token exceeded STALL_LIMIT
//   stall_clr     in   1          clear stall_flag and stall counter
//   token_cnt     out  CNT_W      retired tokens, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset: done=0, cfg_sel=0, pend_valid=0, state=IDLE, stall_cnt=0, stall_flag=0, token_cnt=0.
//   Combinational outputs after reset: ready_out=1, valid_o=0.
//   Combinational path, all cycles:
//     valid_o[i] = valid_in & cfg_sel[i] & ~done[i]
//     take[i]    = valid_o[i] & ready_i[i]
//     ready_out  = &(~cfg_sel | done | ready_i); no ready_out->valid_in loop
//   Fire = valid_in & ready_out.
//     On fire: done <= 0 and token_cnt++.
//     Otherwise: done <= done | take.
//   cfg_sel==0: ready_out=1 and every valid_in token is dropped (sink). Each drop still counts a token.
//   FSM, based on done register:
//     IDLE    (done==0)  -> PARTIAL when valid_in & ~fire & (|take).
//     PARTIAL (done!=0)  -> IDLE on fire.
//   In PARTIAL, valid_in must stay high and data stable (protocol); the block does not check this.
//   Config load:
//     cfg_we in IDLE with no take this cycle: cfg_sel <= cfg_sel_in next cycle.
//     cfg_we in PARTIAL, or in the same cycle as a take: store cfg_sel_in in pend_sel and set
//       pend_valid. Apply it in the cycle after fire, then clear pend_valid.
//     A later cfg_we overwrites pend_sel (last write wins).
//     cfg_we while pend_valid is set, in IDLE: the direct load takes priority and pend_valid clears.
//   Stall watchdog:
//     stall_cnt increments each cycle valid_in & ~ready_out and saturates at STALL_LIMIT.
//     stall_cnt clears on fire.
//     stall_flag sets when stall_cnt==STALL_LIMIT-1 and the cycle still stalls.
//     stall_flag clears only on stall_clr. stall_clr has priority over the set in the same cycle.
//   Latency: zero-cycle combinational valid/ready. done, counters and config are registered.
//   Reset mid-token: done clears, so every selected consumer sees the token again. Upstream must
//     re-present the token.
// TESTING
//   1. cfg_sel=0x1FF, all ready_i=1, valid_in held 8 cycles
//      -> ready_out=1 every cycle, valid_o=0x1FF, token_cnt=8.
//   2. cfg_sel=0x007, ready_i=0x003 cycle0, then 0x004 cycle1
//      -> cycle0 ready_out=0, done=0x003; cycle1 valid_o=0x004, ready_out=1; token_cnt=1, state IDLE.
//   3. cfg_sel=0x000, valid_in=1 for 3 cycles -> ready_out=1, valid_o=0, token_cnt=3.
//   4. PARTIAL with done=0x001, cfg_we with cfg_sel_in=0x010
//      -> cfg_sel unchanged until fire, equals 0x010 the cycle after fire.
//   5. STALL_LIMIT=4, cfg_sel=0x001, ready_i=0, valid_in=1
//      -> stall_flag=1 after 4th stall cycle and stays; stall_clr -> 0.
//   6. rst_n low while done=0x006
//      -> done=0, cfg_sel=0, token_cnt=0 immediately; valid_o=0 until cfg reload.

Source files
------------

// File: rtl/fanout_fork_ctrl.sv
// Eager-fork controller: one ready/valid producer feeding up to NUM_OUT consumers,
// with a registered per-consumer done mask, deferred config load, stall watchdog and token counter.
module fanout_fork_ctrl #(
  parameter int unsigned NUM_OUT     = 9,
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [NUM_OUT-1:0] cfg_sel_in,
  output logic [NUM_OUT-1:0] cfg_sel,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [NUM_OUT-1:0] valid_o,
  input  logic [NUM_OUT-1:0] ready_i,
  output logic               stall_flag,
  input  logic               stall_clr,
  output logic [CNT_W-1:0]   token_cnt
);

  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STALL_LIMIT);

  typedef enum logic {IDLE, PARTIAL} state_t;

  state_t             state, state_nxt;
  logic [NUM_OUT-1:0] done, done_nxt;
  logic [NUM_OUT-1:0] take;
  logic [NUM_OUT-1:0] pend_sel;
  logic               pend_valid;
  logic [SW-1:0]      stall_cnt;
  logic               fire, stall, direct_load;

  always_comb begin
    valid_o     = {NUM_OUT{valid_in}} & cfg_sel & ~done;
    take        = valid_o & ready_i;
    ready_out   = &(~cfg_sel | done | ready_i);
    fire        = valid_in & ready_out;
    stall       = valid_in & ~ready_out;
    done_nxt    = fire ? '0 : (done | take);
    direct_load = cfg_we & (state == IDLE) & ~(|take);
    state_nxt   = state;
    case (state)
      IDLE:    if (valid_in && !fire && (|take)) state_nxt = PARTIAL;
      PARTIAL: if (fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // A deferred write landing in the fire cycle overwrites pend_sel and waits for the next fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_sel    <= '0;
      pend_sel   <= '0;
      pend_valid <= 1'b0;
    end else if (direct_load) begin
      cfg_sel    <= cfg_sel_in;
      pend_valid <= 1'b0;
    end else if (cfg_we) begin
      pend_sel   <= cfg_sel_in;
      pend_valid <= 1'b1;
    end else if (fire && pend_valid) begin
      cfg_sel    <= pend_sel;
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      stall_flag <= 1'b0;
      token_cnt  <= '0;
    end else begin
      if (fire) token_cnt <= token_cnt + 1'b1;
      if (fire || stall_clr) stall_cnt <= '0;
      else if (stall && stall_cnt != LIM) stall_cnt <= stall_cnt + 1'b1;
      if (stall_clr) stall_flag <= 1'b0;
      else if (stall && stall_cnt == LIM - 1'b1) stall_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Directed self-checking bench for fanout_fork_ctrl (NUM_OUT=9, STALL_LIMIT=4).
module tb_fanout_fork_ctrl;

  localparam int unsigned N = 9;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [N-1:0] cfg_sel_in;
  logic [N-1:0] cfg_sel;
  logic         valid_in;
  logic         ready_out;
  logic [N-1:0] valid_o;
  logic [N-1:0] ready_i;
  logic         stall_flag;
  logic         stall_clr;
  logic [W-1:0] token_cnt;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  fanout_fork_ctrl #(.NUM_OUT(N), .STALL_LIMIT(4), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel_in(cfg_sel_in), .cfg_sel(cfg_sel),
    .valid_in(valid_in), .ready_out(ready_out), .valid_o(valid_o), .ready_i(ready_i),
    .stall_flag(stall_flag), .stall_clr(stall_clr), .token_cnt(token_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [N-1:0] sel);
    cfg_we = 1'b1;
    cfg_sel_in = sel;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel_in = '0; valid_in = 1'b0;
    ready_i = '0; stall_clr = 1'b0;
    #12;
    chk("rst_ready_out", 32'(ready_out), 32'd1);
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_token_cnt", 32'(token_cnt), 32'd0);
    chk("rst_cfg_sel", 32'(cfg_sel), 32'h0);
    chk("rst_stall_flag", 32'(stall_flag), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: all nine consumers ready, eight back-to-back tokens
    load_cfg(9'h1FF);
    chk("t1_cfg_sel", 32'(cfg_sel), 32'h1FF);
    ready_i = 9'h1FF; valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("t1_ready_out", 32'(ready_out), 32'd1);
      chk("t1_valid_o", 32'(valid_o), 32'h1FF);
      tick();
    end
    valid_in = 1'b0;
    chk("t1_token_cnt", 32'(token_cnt), 32'd8);

    // 2: split acceptance across two cycles
    load_cfg(9'h007);
    valid_in = 1'b1; ready_i = 9'h003;
    #2;
    chk("t2_c0_ready_out", 32'(ready_out), 32'd0);
    chk("t2_c0_valid_o", 32'(valid_o), 32'h007);
    tick();
    ready_i = 9'h004;
    #2;
    chk("t2_c1_valid_o", 32'(valid_o), 32'h004);
    chk("t2_c1_ready_out", 32'(ready_out), 32'd1);
    tick();
    chk("t2_token_cnt", 32'(token_cnt), 32'd9);
    ready_i = '0;
    #2;
    chk("t2_done_cleared", 32'(valid_o), 32'h007);
    valid_in = 1'b0;

    // 3: empty select mask sinks tokens
    load_cfg(9'h000);
    valid_in = 1'b1; ready_i = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t3_ready_out", 32'(ready_out), 32'd1);
      chk("t3_valid_o", 32'(valid_o), 32'h0);
      tick();
    end
    valid_in = 1'b0;
    chk("t3_token_cnt", 32'(token_cnt), 32'd12);

    // 4: config write while PARTIAL is deferred until after fire
    load_cfg(9'h003);
    valid_in = 1'b1; ready_i = 9'h001;
    tick();
    ready_i = '0;
    load_cfg(9'h010);
    chk("t4_cfg_held0", 32'(cfg_sel), 32'h003);
    chk("t4_valid_o", 32'(valid_o), 32'h002);
    tick();
    chk("t4_cfg_held1", 32'(cfg_sel), 32'h003);
    ready_i = 9'h002;
    #2;
    chk("t4_fire_ready", 32'(ready_out), 32'd1);
    tick();
    chk("t4_cfg_applied", 32'(cfg_sel), 32'h010);
    chk("t4_token_cnt", 32'(token_cnt), 32'd13);
    chk("t4_no_stall", 32'(stall_flag), 32'd0);
    valid_in = 1'b0; ready_i = '0;

    // 5: watchdog with STALL_LIMIT=4
    load_cfg(9'h001);
    valid_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("t5_flag_after_%0d", i), 32'(stall_flag), (i >= 4) ? 32'd1 : 32'd0);
    end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("t5_flag_cleared", 32'(stall_flag), 32'd0);
    tick();
    chk("t5_cnt_restarted", 32'(stall_flag), 32'd0);
    ready_i = 9'h001;
    tick();
    chk("t5_token_cnt", 32'(token_cnt), 32'd14);
    valid_in = 1'b0; ready_i = '0;

    // 6: reset with a partially accepted token
    load_cfg(9'h007);
    valid_in = 1'b1; ready_i = 9'h006;
    tick();
    ready_i = '0;
    #2;
    chk("t6_pre_valid_o", 32'(valid_o), 32'h001);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_token_cnt", 32'(token_cnt), 32'd0);
    chk("t6_rst_cfg_sel", 32'(cfg_sel), 32'h0);
    chk("t6_rst_valid_o", 32'(valid_o), 32'h0);
    chk("t6_rst_ready_out", 32'(ready_out), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("t6_valid_o_noload", 32'(valid_o), 32'h0);
    load_cfg(9'h007);
    chk("t6_valid_o_reload", 32'(valid_o), 32'h007);
    chk("t6_token_cnt", 32'(token_cnt), 32'd2);
    valid_in = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
